// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage control and the ALU.
// The ALU is the slave; the control unit (or bench) is the master.
interface alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] out;
    logic [1:0]  comp;
    logic        divdone;

    modport master (
        output a, b, ctrl,
        input  out, comp, divdone
    );

    modport slave (
        input  a, b, ctrl,
        output out, comp, divdone
    );
endinterface

// File: rtl/alu.sv
// 32-bit MIPS integer ALU: single-cycle combinational ops plus a 16-iteration
// radix-4 restoring divider (unsigned and signed) with quotient/remainder select.
module alu (
    input logic   clk,
    input logic   divrst,
    alu_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] div_q;
    logic [31:0] a_q;
    logic        sgn_q;
    logic        nega_q;
    logic        negb_q;

    logic        is_div;
    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign is_div    = (bus.ctrl[3:2] == 2'b11);
    assign op_signed = bus.ctrl[1];
    assign a_mag     = (op_signed && bus.a[31]) ? -bus.a : bus.a;
    assign b_mag     = (op_signed && bus.b[31]) ? -bus.b : bus.b;

    // One radix-4 step: pick the largest multiple of the divisor that fits.
    logic [34:0] r_ext, d1, d2, d3, t1, t2, t3;
    logic [1:0]  digit;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    always_comb begin
        r_ext = {1'b0, rem_q, quo_q[31:30]};
        d1    = {3'b000, div_q};
        d2    = {2'b00, div_q, 1'b0};
        d3    = d1 + d2;
        t1    = r_ext - d1;
        t2    = r_ext - d2;
        t3    = r_ext - d3;
        if (!t3[34]) begin
            digit    = 2'd3;
            rem_step = t3[31:0];
        end else if (!t2[34]) begin
            digit    = 2'd2;
            rem_step = t2[31:0];
        end else if (!t1[34]) begin
            digit    = 2'd1;
            rem_step = t1[31:0];
        end else begin
            digit    = 2'd0;
            rem_step = r_ext[31:0];
        end
        quo_step = {quo_q[29:0], digit};

        if (div_q == 32'h0) begin
            quo_fin = 32'hFFFF_FFFF;
            rem_fin = a_q;
        end else begin
            quo_fin = (sgn_q && (nega_q ^ negb_q)) ? -quo_step : quo_step;
            rem_fin = (sgn_q && nega_q) ? -rem_step : rem_step;
        end
    end

    always_ff @(posedge clk or negedge divrst) begin
        if (!divrst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            quo_q   <= 32'h0;
            rem_q   <= 32'h0;
            div_q   <= 32'h0;
            a_q     <= 32'h0;
            sgn_q   <= 1'b0;
            nega_q  <= 1'b0;
            negb_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_div) begin
                        a_q     <= bus.a;
                        sgn_q   <= op_signed;
                        nega_q  <= op_signed & bus.a[31];
                        negb_q  <= op_signed & bus.b[31];
                        quo_q   <= a_mag;
                        div_q   <= b_mag;
                        rem_q   <= 32'h0;
                        cnt_q   <= 5'd16;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        quo_q   <= quo_fin;
                        rem_q   <= rem_fin;
                        state_q <= StDone;
                    end else begin
                        quo_q <= quo_step;
                        rem_q <= rem_step;
                    end
                end
                StDone: begin
                    if (!is_div) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [31:0] result;

    always_comb begin
        result = 32'h0;
        case (bus.ctrl)
            4'b0000: result = bus.a + bus.b;
            4'b0001: result = bus.a - bus.b;
            4'b0010: result = bus.a & bus.b;
            4'b0011: result = bus.a | bus.b;
            4'b0100: result = bus.a ^ bus.b;
            4'b0101: result = ~(bus.a | bus.b);
            4'b0110: result = {31'h0, $signed(bus.a) < $signed(bus.b)};
            4'b0111: result = {31'h0, bus.a < bus.b};
            4'b1000: result = bus.b << bus.a[4:0];
            4'b1001: result = bus.b >> bus.a[4:0];
            4'b1010: result = $signed(bus.b) >>> bus.a[4:0];
            4'b1011: result = {bus.b[15:0], 16'h0};
            default: begin
                if (state_q == StDone) begin
                    result = bus.ctrl[0] ? rem_q : quo_q;
                end
            end
        endcase
    end

    assign bus.out     = result;
    assign bus.comp    = {$signed(bus.a) < $signed(bus.b), bus.a == bus.b};
    assign bus.divdone = (state_q == StDone);

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected responses, a negedge
// monitor pops and compares them when the DUT presents a result.
module tb_alu;

    logic clk;
    logic divrst;

    alu_if bus ();

    alu u_alu (
        .clk    (clk),
        .divrst (divrst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic [1:0]  comp;
        bit          chk_comp;
        bit          exp_done;
        bit          wait_done;
        int          exp_wait;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] o, input logic [1:0] c, input bit cc,
                        input bit dn, input bit wt, input int ew, input string nm);
        exp_t e;
        e.out = o; e.comp = c; e.chk_comp = cc; e.exp_done = dn;
        e.wait_done = wt; e.exp_wait = ew; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: immediate entries compare at the next negedge, divide entries
    // wait (bounded) for divdone and also check how many cycles it took.
    initial begin
        int   waited;
        exp_t e;
        waited = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb[0];
                if (!e.wait_done) begin
                    chk({e.name, ".out"}, bus.out, e.out);
                    chk({e.name, ".done"}, {31'h0, bus.divdone}, {31'h0, e.exp_done});
                    if (e.chk_comp) chk({e.name, ".comp"}, {30'h0, bus.comp}, {30'h0, e.comp});
                    void'(sb.pop_front());
                end else if (bus.divdone) begin
                    chk({e.name, ".out"}, bus.out, e.out);
                    if (e.exp_wait >= 0) chk({e.name, ".latency"}, waited, e.exp_wait);
                    void'(sb.pop_front());
                    waited = 0;
                end else begin
                    waited++;
                    if (waited > 40) begin
                        checks++;
                        errors++;
                        $display("FAIL %s.timeout: got divdone=0 after %0d cycles expected 1",
                                 e.name, waited);
                        void'(sb.pop_front());
                        waited = 0;
                    end
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic comb(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] o, input logic [1:0] cp, input string nm);
        @(posedge clk);
        #1;
        bus.ctrl = c; bus.a = a; bus.b = b;
        push(o, cp, 1'b1, 1'b0, 1'b0, -1, nm);
        drain();
    endtask

    task automatic divide(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input string nm);
        @(posedge clk);
        #1;
        bus.ctrl = c; bus.a = a; bus.b = b;
        push(q, 2'b00, 1'b0, 1'b1, 1'b1, 17, {nm, ".quo"});
        drain();
        @(posedge clk);
        #1;
        bus.ctrl = c | 4'b0001;
        push(r, 2'b00, 1'b0, 1'b1, 1'b1, 0, {nm, ".rem"});
        drain();
        @(posedge clk);
        #1;
        bus.ctrl = 4'b0000;
    endtask

    initial begin
        divrst   = 1'b0;
        bus.ctrl = 4'b1100;
        bus.a    = 32'd100;
        bus.b    = 32'd7;
        #1;
        push(32'h0, 2'b00, 1'b1, 1'b0, 1'b0, -1, "reset");
        drain();
        @(posedge clk);
        #1;
        divrst   = 1'b1;
        bus.ctrl = 4'b0000;

        comb(4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 2'b00, "add");
        comb(4'b0001, 32'h7FFF_FFFF, 32'h1, 32'h7FFF_FFFE, 2'b00, "sub");
        comb(4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h1, 2'b10, "slt");
        comb(4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'b10, "sltu");
        comb(4'b0010, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 2'b10, "and");
        comb(4'b0011, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 2'b10, "or");
        comb(4'b0100, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 2'b10, "xor");
        comb(4'b0101, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h000F_ED00, 2'b10, "nor");
        comb(4'b1000, 32'h4, 32'h8000_0010, 32'h0000_0100, 2'b00, "sll");
        comb(4'b1001, 32'h4, 32'h8000_0010, 32'h0800_0001, 2'b00, "srl");
        comb(4'b1010, 32'h4, 32'h8000_0010, 32'hF800_0001, 2'b00, "sra");
        comb(4'b1011, 32'h4, 32'h8000_0010, 32'h0010_0000, 2'b00, "lui");
        comb(4'b0000, 32'h1234, 32'h1234, 32'h2468, 2'b01, "add_eq");

        // DIVU 100/7, then flip to the signed encoding while DONE: no recompute.
        @(posedge clk);
        #1;
        bus.ctrl = 4'b1100; bus.a = 32'd100; bus.b = 32'd7;
        push(32'h0E, 2'b00, 1'b0, 1'b1, 1'b1, 17, "divu.quo");
        drain();
        @(posedge clk);
        #1;
        bus.ctrl = 4'b1101;
        push(32'h2, 2'b00, 1'b0, 1'b1, 1'b1, 0, "divu.rem");
        drain();
        @(posedge clk);
        #1;
        bus.ctrl = 4'b1110;
        push(32'h0E, 2'b00, 1'b0, 1'b1, 1'b0, -1, "divu.hold");
        drain();
        @(posedge clk);
        #1;
        bus.ctrl = 4'b0000;

        divide(4'b1110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_neg");
        divide(4'b1100, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5, "divu_zero");
        divide(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "div_ovf");

        // Abort at iteration 8, then a full divide with operands changed after edge 0.
        @(posedge clk);
        #1;
        bus.ctrl = 4'b1100; bus.a = 32'hFFFF_FFFF; bus.b = 32'h10;
        repeat (9) @(posedge clk);
        #1;
        divrst = 1'b0;
        push(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, -1, "abort");
        drain();
        @(posedge clk);
        #1;
        divrst = 1'b1;
        push(32'h0FFF_FFFF, 2'b00, 1'b0, 1'b1, 1'b1, 17, "restart.quo");
        @(posedge clk);
        #1;
        bus.a = 32'h0; bus.b = 32'h0;
        drain();
        @(posedge clk);
        #1;
        bus.ctrl = 4'b1101;
        push(32'hF, 2'b00, 1'b0, 1'b1, 1'b1, 0, "restart.rem");
        drain();

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
